// File: rtl/alu_result_pkg.sv
// Shared widths and entry layout for the ALU result buffer.
// Optional forwarding is enabled with ALU_RESULT_BUFFER_FWD_EN.
package alu_result_pkg;

  localparam int RES_DATA_WIDTH = 32;
  localparam int RES_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [RES_DATA_WIDTH-1:0] result;
    logic                      zero;
    logic                      negative;
    logic [RES_ADDR_WIDTH-1:0] rd;
    logic                      we;
  } alu_result_entry_t;

endpackage

// File: rtl/alu_result_fwd_match.sv
// Youngest-first match of one read address against buffered results.
// Used only when ALU_RESULT_BUFFER_FWD_EN is defined.
module alu_result_fwd_match
  import alu_result_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  alu_result_entry_t           mem [DEPTH],
  input  logic [DEPTH-1:0]            valid,
  input  logic [PTR_W-1:0]            head,
  input  logic [RES_ADDR_WIDTH-1:0]   addr,
  output logic                        hit,
  output logic [RES_DATA_WIDTH-1:0]   data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && mem[idx].we &&
          mem[idx].rd == addr && addr != '0) begin
        hit  = 1'b1;
        data = mem[idx].result;
      end
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Registered ALU result FIFO with retirement-order status flags.
// Define ALU_RESULT_BUFFER_FWD_EN to add two forwarding read ports.
module alu_result_buffer
  import alu_result_pkg::*;
#(
  parameter int DATA_WIDTH = RES_DATA_WIDTH,
  parameter int ADDR_WIDTH = RES_ADDR_WIDTH,
  parameter int DEPTH      = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_result,
  input  logic                         in_zero,
  input  logic                         in_negative,
  input  logic [ADDR_WIDTH-1:0]        in_rd,
  input  logic                         in_we,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_result,
  output logic [ADDR_WIDTH-1:0]        out_rd,
  output logic                         out_we,
  output logic                         flag_zero,
  output logic                         flag_negative,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef ALU_RESULT_BUFFER_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0]        fwd_addr_a,
  input  logic [ADDR_WIDTH-1:0]        fwd_addr_b,
  output logic                         fwd_hit_a,
  output logic                         fwd_hit_b,
  output logic [DATA_WIDTH-1:0]        fwd_data_a,
  output logic [DATA_WIDTH-1:0]        fwd_data_b
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  alu_result_entry_t mem_q [DEPTH];
  alu_result_entry_t mem_d [DEPTH];
  alu_result_entry_t hd;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rdy_q;
  logic             fz_q, fz_d;
  logic             fn_q, fn_d;
  logic             push, pop;

  // rdy_q keeps in_ready low while reset is held.
  assign in_ready  = rdy_q && (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign hd            = mem_q[head_q];
  assign out_result    = hd.result;
  assign out_rd        = hd.rd;
  assign out_we        = hd.we;
  assign flag_zero     = fz_q;
  assign flag_negative = fn_q;
  assign count         = count_q;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    fz_d    = fz_q;
    fn_d    = fn_q;
    if (push) begin
      mem_d[tail_q] = '{result:   in_result,
                        zero:     in_zero,
                        negative: in_negative,
                        rd:       in_rd,
                        we:       in_we};
      tail_d = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
      fz_d   = hd.zero;
      fn_d   = hd.negative;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdy_q   <= 1'b0;
      fz_q    <= 1'b0;
      fn_q    <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdy_q   <= 1'b1;
      fz_q    <= fz_d;
      fn_q    <= fn_d;
    end
  end

`ifdef ALU_RESULT_BUFFER_FWD_EN
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] off;

  // Slot i is live when its distance from head is below count.
  always_comb begin
    vld = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = PTR_W'(i) - head_q;
      vld[i] = CNT_W'(off) < count_q;
    end
  end

  alu_result_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
    .mem   (mem_q),
    .valid (vld),
    .head  (head_q),
    .addr  (fwd_addr_a),
    .hit   (fwd_hit_a),
    .data  (fwd_data_a)
  );

  alu_result_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
    .mem   (mem_q),
    .valid (vld),
    .head  (head_q),
    .addr  (fwd_addr_b),
    .hit   (fwd_hit_b),
    .data  (fwd_data_b)
  );
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer.
// Forwarding checks run when ALU_RESULT_BUFFER_FWD_EN is defined.
module tb_alu_result_buffer;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        n;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic        in_zero = 1'b0;
  logic        in_negative = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_we = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        flag_zero;
  logic        flag_negative;
  logic [1:0]  count;
`ifdef ALU_RESULT_BUFFER_FWD_EN
  logic [4:0]  fwd_addr_a = '0;
  logic [4:0]  fwd_addr_b = '0;
  logic        fwd_hit_a, fwd_hit_b;
  logic [31:0] fwd_data_a, fwd_data_b;
`endif

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_zero       (in_zero),
    .in_negative   (in_negative),
    .in_rd         (in_rd),
    .in_we         (in_we),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_we        (out_we),
    .flag_zero     (flag_zero),
    .flag_negative (flag_negative),
    .count         (count)
`ifdef ALU_RESULT_BUFFER_FWD_EN
    ,
    .fwd_addr_a    (fwd_addr_a),
    .fwd_addr_b    (fwd_addr_b),
    .fwd_hit_a     (fwd_hit_a),
    .fwd_hit_b     (fwd_hit_b),
    .fwd_data_a    (fwd_data_a),
    .fwd_data_b    (fwd_data_b)
`endif
  );

  always #5 clock = ~clock;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t sb[$];
  logic m_alive = 1'b0;
  logic m_fz = 1'b0;
  logic m_fn = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

`ifdef ALU_RESULT_BUFFER_FWD_EN
  task automatic fwd_model(input logic [4:0] a,
                           output logic h,
                           output logic [31:0] d);
    h = 1'b0;
    d = '0;
    foreach (sb[i])
      if (sb[i].we && sb[i].rd == a && a != 0) begin
        h = 1'b1;
        d = sb[i].r;
      end
  endtask
`endif

  // Called just after a falling edge; ends on the next falling edge.
  task automatic step(input logic v, input logic [31:0] r,
                      input logic z, input logic n,
                      input logic [4:0] rd, input logic we,
                      input logic ordy);
    ent_t e;
    logic do_push, do_pop;
    logic rdy_m;
    in_valid    = v;
    in_result   = r;
    in_zero     = z;
    in_negative = n;
    in_rd       = rd;
    in_we       = we;
    out_ready   = ordy;
`ifdef ALU_RESULT_BUFFER_FWD_EN
    fwd_addr_a  = 5'($urandom_range(0, 7));
    fwd_addr_b  = rd;
`endif
    #1;
    rdy_m = m_alive && (sb.size() < DEPTH);
    chk("count", 32'(count), 32'(sb.size()));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(rdy_m));
`ifdef ALU_RESULT_BUFFER_FWD_EN
    begin
      logic        h;
      logic [31:0] d;
      fwd_model(fwd_addr_a, h, d);
      chk("fwd_hit_a", 32'(fwd_hit_a), 32'(h));
      chk("fwd_data_a", fwd_data_a, d);
      fwd_model(fwd_addr_b, h, d);
      chk("fwd_hit_b", 32'(fwd_hit_b), 32'(h));
      chk("fwd_data_b", fwd_data_b, d);
    end
`endif
    do_pop  = ordy && sb.size() != 0;
    do_push = v && rdy_m;
    if (do_pop) begin
      e = sb.pop_front();
      chk("out_result", out_result, e.r);
      chk("out_rd", 32'(out_rd), 32'(e.rd));
      chk("out_we", 32'(out_we), 32'(e.we));
      m_fz = e.z;
      m_fn = e.n;
    end
    if (do_push) begin
      e.r  = r;
      e.z  = z;
      e.n  = n;
      e.rd = rd;
      e.we = we;
      sb.push_back(e);
    end
    @(posedge clock);
    if (reset_n) m_alive = 1'b1;
    #1;
    chk("flag_zero", 32'(flag_zero), 32'(m_fz));
    chk("flag_neg", 32'(flag_negative), 32'(m_fn));
    @(negedge clock);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, ordy);
  endtask

  task automatic push_r(input logic [31:0] r, input logic [4:0] rd,
                        input logic ordy);
    step(1'b1, r, r == 0, r[31], rd, 1'b1, ordy);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_flags", {30'd0, flag_zero, flag_negative}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(1'b0);

    push_r(32'h5, 5'd3, 1'b0);
    chk("lat_out_result", out_result, 32'h5);
    chk("lat_out_rd", 32'(out_rd), 32'd3);
    idle(1'b1);
    idle(1'b0);

    push_r(32'hFFFF_FFFF, 5'd4, 1'b0);
    push_r(32'h0, 5'd5, 1'b0);
    chk("full_count", 32'(count), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    idle(1'b1);
    chk("seq_neg", 32'(flag_negative), 32'd1);
    idle(1'b1);
    chk("seq_zero", 32'(flag_zero), 32'd1);
    chk("seq_neg2", 32'(flag_negative), 32'd0);

    step(1'b1, 32'h1234, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0);
    push_r(32'h8000_0001, 5'd2, 1'b0);
    push_r(32'h9999, 5'd1, 1'b1);
    chk("fullpop_count", 32'(count), 32'd1);
    idle(1'b1);

    for (int i = 0; i < 8; i++) begin
      push_r(32'(i) * 32'h0101_0101, 5'(i), 1'b1);
      chk("strm_cnt_le1", 32'(count <= 2'd1), 32'd1);
    end
    idle(1'b1);

    push_r(32'hAAAA, 5'd3, 1'b0);
    push_r(32'hBBBB, 5'd4, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    sb.delete();
    m_alive = 1'b0;
    m_fz = 1'b0;
    m_fn = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(1'b1);
    chk("post_rst_result", out_result, 32'd0);
    chk("post_rst_rd", 32'(out_rd), 32'd0);
    chk("post_rst_we", 32'(out_we), 32'd0);
    idle(1'b1);

`ifdef ALU_RESULT_BUFFER_FWD_EN
    push_r(32'h11, 5'd7, 1'b0);
    push_r(32'h22, 5'd7, 1'b0);
    fwd_addr_a = 5'd7;
    fwd_addr_b = 5'd0;
    #1;
    chk("fwd7_hit", 32'(fwd_hit_a), 32'd1);
    chk("fwd7_data", fwd_data_a, 32'h22);
    chk("fwd0_hit", 32'(fwd_hit_b), 32'd0);
    chk("fwd0_data", fwd_data_b, 32'd0);
    idle(1'b1);
    idle(1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
